// File: rtl/sim_exit_monitor.sv
// sim_exit_monitor: classifies a run as pass/fail/timeout from the harness exit strobe,
// latching exit code and RUN cycle count, with a periodic heartbeat while running.
module sim_exit_monitor #(
  parameter int EXIT_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int HB_LOG2    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic [CNT_WIDTH-1:0]  max_cycles_i,
  input  logic                  exit_valid_i,
  input  logic [EXIT_WIDTH-1:0] exit_value_i,
  output logic                  running_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [EXIT_WIDTH-1:0] exit_code_o,
  output logic [CNT_WIDTH-1:0]  cycle_count_o,
  output logic                  heartbeat_o
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXITED, S_TIMEOUT} state_t;
  state_t r_state, w_next;
  logic [CNT_WIDTH-1:0]  r_cnt, r_max, w_cnt_d, w_max_d;
  logic [EXIT_WIDTH-1:0] r_code, w_code_d;
  logic r_done, r_pass, r_fail, r_to, r_hb;
  logic w_done_d, w_pass_d, w_fail_d, w_to_d, w_hb_d;
  logic [CNT_WIDTH:0] w_inc;
  logic w_run, w_idle, w_limit, w_sat, w_wrap, w_exit, w_step;
  assign w_inc   = {1'b0, r_cnt} + 1'b1;
  assign w_run   = r_state == S_RUN;
  assign w_idle  = r_state == S_IDLE;
  // Extra top bit on w_inc keeps the limit compare exact at the counter's ceiling.
  assign w_limit = (r_max != '0) && (w_inc >= {1'b0, r_max});
  assign w_sat   = &r_cnt;
  assign w_wrap  = !w_sat && (w_inc[HB_LOG2-1:0] == '0);
  assign w_exit  = w_run && !clear_i && exit_valid_i;
  assign w_step  = w_run && !clear_i && !exit_valid_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = clear_i ? S_IDLE :
             w_idle  ? (en_i ? S_RUN : S_IDLE) :
             w_run   ? (exit_valid_i ? S_EXITED : w_limit ? S_TIMEOUT : S_RUN) :
             r_state;
  end
  always_comb begin
    w_max_d  = (!clear_i && w_idle && en_i) ? max_cycles_i : clear_i ? '0 : r_max;
    w_cnt_d  = (clear_i || w_idle) ? '0 : (w_step && !w_sat) ? w_inc[CNT_WIDTH-1:0] : r_cnt;
    w_code_d = clear_i ? '0 : w_exit ? exit_value_i : r_code;
    w_pass_d = clear_i ? 1'b0 : w_exit ? (exit_value_i == '0) : r_pass;
    w_fail_d = clear_i ? 1'b0 : w_exit ? (exit_value_i != '0) : r_fail;
    w_to_d   = clear_i ? 1'b0 : (w_step && w_limit) ? 1'b1 : r_to;
    w_done_d = clear_i ? 1'b0 : (w_exit || (w_step && w_limit)) ? 1'b1 : r_done;
    w_hb_d   = w_step && !w_limit && w_wrap;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_max  <= '0;
      r_code <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      r_to   <= 1'b0;
      r_hb   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_d;
      r_max  <= w_max_d;
      r_code <= w_code_d;
      r_done <= w_done_d;
      r_pass <= w_pass_d;
      r_fail <= w_fail_d;
      r_to   <= w_to_d;
      r_hb   <= w_hb_d;
    end
  assign running_o     = w_run;
  assign done_o        = r_done;
  assign pass_o        = r_pass;
  assign fail_o        = r_fail;
  assign timeout_o     = r_to;
  assign exit_code_o   = r_code;
  assign cycle_count_o = r_cnt;
  assign heartbeat_o   = r_hb;
endmodule

// File: tb/tb_sim_exit_monitor.sv
// tb_sim_exit_monitor: directed and random checks of sim_exit_monitor against a
// cycle-level behavioural model of the run/exit/timeout rules.
module tb_sim_exit_monitor;
  localparam int EW = 16;
  localparam int CW = 8;
  localparam int HB = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [EW-1:0] Z = '0;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, clr = 1'b0, ev = 1'b0;
  logic [EW-1:0] val = '0;
  logic [CW-1:0] maxc = '0;
  logic running_o, done_o, pass_o, fail_o, timeout_o, heartbeat_o;
  logic [EW-1:0] exit_code_o;
  logic [CW-1:0] cycle_count_o;
  int vectors = 0, miscompares = 0;
  int m_st, m_cnt, m_max;
  bit m_done, m_pass, m_fail, m_to, m_hb;
  logic [EW-1:0] m_code;

  sim_exit_monitor #(.EXIT_WIDTH(EW), .CNT_WIDTH(CW), .HB_LOG2(HB)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clear_i(clr), .max_cycles_i(maxc),
    .exit_valid_i(ev), .exit_value_i(val), .running_o(running_o), .done_o(done_o),
    .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o), .exit_code_o(exit_code_o),
    .cycle_count_o(cycle_count_o), .heartbeat_o(heartbeat_o));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_max = 0; m_code = '0;
    m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_hb = 0;
  endtask

  // States: 0 idle, 1 run, 2 exited, 3 timed out.
  task automatic model_step();
    m_hb = 0;
    if (clr) model_reset();
    else if (m_st == 0) begin
      if (en) begin m_st = 1; m_max = int'(maxc); m_cnt = 0; end
    end else if (m_st == 1) begin
      if (ev) begin
        m_st = 2; m_code = val; m_pass = (val == 0); m_fail = !m_pass; m_done = 1;
      end else if (m_max != 0 && m_cnt + 1 >= m_max) begin
        m_cnt++; m_st = 3; m_to = 1; m_done = 1;
      end else if (m_cnt < CMAX) begin
        m_cnt++; m_hb = (m_cnt % (1 << HB)) == 0;
      end
    end
  endtask

  function automatic logic [29:0] want();
    return {m_st == 1, m_done, m_pass, m_fail, m_to, m_hb, m_code, m_cnt[CW-1:0]};
  endfunction

  function automatic logic [29:0] got();
    return {running_o, done_o, pass_o, fail_o, timeout_o, heartbeat_o, exit_code_o, cycle_count_o};
  endfunction

  task automatic cyc(input logic e, input logic c, input logic v, input logic [EW-1:0] x);
    en = e; clr = c; ev = v; val = x;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    vectors++;
    if (got() !== 30'h0) begin miscompares++; $display("FAIL reset: got %h want 0", got()); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_pass();
    maxc = '0;
    cyc(1'b1, 1'b0, 1'b0, Z);
    vectors++;
    if (got() !== want()) begin miscompares++; $display("FAIL pass_start: got %h want %h", got(), want()); end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, Z);
      vectors++;
      if (got() !== want()) begin miscompares++; $display("FAIL pass_run %0d: got %h want %h", i, got(), want()); end
    end
    cyc(1'b0, 1'b0, 1'b1, Z);
    vectors++;
    if ({running_o, done_o, pass_o, fail_o, timeout_o, exit_code_o, cycle_count_o} !== {5'b01100, 16'h0, 8'd10}) begin
      miscompares++;
      $display("FAIL pass_result: got %h want %h", {running_o, done_o, pass_o, fail_o, timeout_o, exit_code_o, cycle_count_o}, {5'b01100, 16'h0, 8'd10});
    end
    cyc(1'b1, 1'b1, 1'b0, Z);
    vectors++;
    if (got() !== 30'h0) begin miscompares++; $display("FAIL pass_clear: got %h want 0", got()); end
  endtask

  task automatic test_fail_hold();
    maxc = '0;
    cyc(1'b1, 1'b0, 1'b0, Z);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, Z);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, (i == 0) ? 16'h2A : 16'h7);
      vectors++;
      if ({done_o, fail_o, pass_o, exit_code_o, cycle_count_o} !== {3'b110, 16'h2A, 8'd3}) begin
        miscompares++;
        $display("FAIL fail_hold %0d: got %h want %h", i, {done_o, fail_o, pass_o, exit_code_o, cycle_count_o}, {3'b110, 16'h2A, 8'd3});
      end
    end
    cyc(1'b0, 1'b1, 1'b0, Z);
  endtask

  task automatic test_timeout();
    maxc = 8'd5;
    cyc(1'b1, 1'b0, 1'b0, Z);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, Z);
      vectors++;
      if (got() !== want()) begin miscompares++; $display("FAIL timeout_run %0d: got %h want %h", i, got(), want()); end
    end
    vectors++;
    if ({running_o, timeout_o, done_o, pass_o, fail_o, exit_code_o, cycle_count_o} !== {5'b01100, 16'h0, 8'd5}) begin
      miscompares++;
      $display("FAIL timeout_result: got %h want %h", {running_o, timeout_o, done_o, pass_o, fail_o, exit_code_o, cycle_count_o}, {5'b01100, 16'h0, 8'd5});
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 16'h9);
    vectors++;
    if (got() !== want()) begin miscompares++; $display("FAIL timeout_hold: got %h want %h", got(), want()); end
    cyc(1'b0, 1'b1, 1'b0, Z);
    cyc(1'b1, 1'b0, 1'b0, Z);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, Z);
    cyc(1'b0, 1'b0, 1'b1, Z);
    vectors++;
    if ({pass_o, timeout_o, done_o, cycle_count_o} !== {3'b101, 8'd4}) begin
      miscompares++;
      $display("FAIL exit_beats_limit: got %h want %h", {pass_o, timeout_o, done_o, cycle_count_o}, {3'b101, 8'd4});
    end
    cyc(1'b0, 1'b1, 1'b0, Z);
  endtask

  task automatic test_heartbeat();
    int pulses = 0;
    maxc = '0;
    cyc(1'b1, 1'b0, 1'b0, Z);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b0, 1'b0, Z);
      pulses += int'(heartbeat_o);
      vectors++;
      if (heartbeat_o !== (i % 4 == 0)) begin miscompares++; $display("FAIL hb_cycle %0d: got %b want %b", i, heartbeat_o, i % 4 == 0); end
    end
    vectors++;
    if (pulses != 3) begin miscompares++; $display("FAIL hb_count: got %0d want 3", pulses); end
    cyc(1'b0, 1'b0, 1'b1, Z);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, Z);
      vectors++;
      if (heartbeat_o !== 1'b0) begin miscompares++; $display("FAIL hb_exited %0d: got %b want 0", i, heartbeat_o); end
    end
    cyc(1'b0, 1'b1, 1'b0, Z);
    maxc = 8'd4;
    cyc(1'b1, 1'b0, 1'b0, Z);
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 1'b0, 1'b0, Z);
      vectors++;
      if (got() !== want() || heartbeat_o !== 1'b0) begin miscompares++; $display("FAIL hb_timeout %0d: got %h want %h", i, got(), want()); end
    end
    cyc(1'b0, 1'b1, 1'b0, Z);
  endtask

  task automatic test_idle_exit();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'h5);
      vectors++;
      if (got() !== 30'h0) begin miscompares++; $display("FAIL idle_exit %0d: got %h want 0", i, got()); end
    end
    maxc = '0;
    cyc(1'b1, 1'b0, 1'b1, 16'h5);
    vectors++;
    if ({running_o, done_o, cycle_count_o} !== {2'b10, 8'd0}) begin miscompares++; $display("FAIL idle_enter: got %h want 200", {running_o, done_o, cycle_count_o}); end
    cyc(1'b0, 1'b0, 1'b1, 16'h5);
    vectors++;
    if ({running_o, done_o, fail_o, exit_code_o, cycle_count_o} !== {3'b011, 16'h5, 8'd0}) begin
      miscompares++;
      $display("FAIL idle_then_exit: got %h want %h", {running_o, done_o, fail_o, exit_code_o, cycle_count_o}, {3'b011, 16'h5, 8'd0});
    end
    cyc(1'b0, 1'b1, 1'b0, Z);
  endtask

  task automatic test_clear_priority();
    maxc = '0;
    cyc(1'b1, 1'b0, 1'b0, Z);
    cyc(1'b0, 1'b0, 1'b0, Z);
    cyc(1'b0, 1'b1, 1'b1, 16'h3);
    vectors++;
    if (got() !== 30'h0) begin miscompares++; $display("FAIL clear_vs_exit: got %h want 0", got()); end
    cyc(1'b1, 1'b1, 1'b0, Z);
    vectors++;
    if (running_o !== 1'b0) begin miscompares++; $display("FAIL clear_vs_en: got %b want 0", running_o); end
    cyc(1'b1, 1'b0, 1'b0, Z);
    vectors++;
    if (running_o !== 1'b1) begin miscompares++; $display("FAIL en_after_clear: got %b want 1", running_o); end
    cyc(1'b0, 1'b1, 1'b0, Z);
  endtask

  task automatic test_async_reset();
    maxc = '0;
    cyc(1'b1, 1'b0, 1'b0, Z);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 1'b0, Z);
    vectors++;
    if ({running_o, cycle_count_o} !== {1'b1, 8'd100}) begin miscompares++; $display("FAIL pre_reset: got %h want 164", {running_o, cycle_count_o}); end
    #2 rst_n = 1'b0;
    #1 model_reset();
    vectors++;
    if (got() !== 30'h0) begin miscompares++; $display("FAIL async_reset: got %h want 0", got()); end
    @(negedge clk) rst_n = 1'b1;
    maxc = 8'd3;
    cyc(1'b1, 1'b0, 1'b0, Z);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, Z);
    vectors++;
    if ({timeout_o, done_o, cycle_count_o} !== {2'b11, 8'd3}) begin miscompares++; $display("FAIL post_reset_timeout: got %h want 303", {timeout_o, done_o, cycle_count_o}); end
    cyc(1'b0, 1'b1, 1'b0, Z);
    vectors++;
    if (got() !== 30'h0) begin miscompares++; $display("FAIL clear_timeout: got %h want 0", got()); end
  endtask

  task automatic test_saturation();
    maxc = '0;
    cyc(1'b1, 1'b0, 1'b0, Z);
    for (int i = 0; i < 262; i++) begin
      cyc(1'b0, 1'b0, 1'b0, Z);
      vectors++;
      if (got() !== want()) begin miscompares++; $display("FAIL sat_run %0d: got %h want %h", i, got(), want()); end
    end
    vectors++;
    if ({running_o, cycle_count_o} !== {1'b1, 8'hFF}) begin miscompares++; $display("FAIL sat_value: got %h want 1ff", {running_o, cycle_count_o}); end
    cyc(1'b0, 1'b0, 1'b1, 16'h1);
    vectors++;
    if ({fail_o, cycle_count_o} !== {1'b1, 8'hFF}) begin miscompares++; $display("FAIL sat_exit: got %h want 1ff", {fail_o, cycle_count_o}); end
    cyc(1'b0, 1'b1, 1'b0, Z);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      maxc = ($urandom % 4 == 0) ? '0 : CW'($urandom_range(1, 12));
      cyc($urandom % 4 == 0, $urandom % 20 == 0, $urandom % 10 == 0, ($urandom % 3 == 0) ? Z : EW'($urandom));
      vectors++;
      if (got() !== want()) begin miscompares++; $display("FAIL random %0d: got %h want %h", i, got(), want()); end
    end
    cyc(1'b0, 1'b1, 1'b0, Z);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_hold();
    test_timeout();
    test_heartbeat();
    test_idle_exit();
    test_clear_priority();
    test_async_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
